// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID-side inputs, registered EX-side outputs and hazard controls.
// master = decode side driving ID fields; slave = the pipeline register.
interface id_ex_stage_if;
  logic        Flush;
  logic [31:0] PC4_ID, ReadData1_ID, ReadData2_ID, SignExt_ID;
  logic [4:0]  Rs_ID, Rt_ID, Rd_ID;
  logic        RegDst_ID, ALUSrc_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, RegWrite_ID;
  logic [2:0]  ALUOp_ID;

  logic [31:0] PC4_EX, ReadData1_EX, ReadData2_EX, SignExt_EX;
  logic [4:0]  Rs_EX, Rt_EX, Rd_EX;
  logic        RegDst_EX, ALUSrc_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, RegWrite_EX;
  logic [2:0]  ALUOp_EX;

  logic        PCWrite, IFID_Write, Stall;
  logic [15:0] BubbleCount;

  modport master (
    output Flush, PC4_ID, ReadData1_ID, ReadData2_ID, SignExt_ID, Rs_ID, Rt_ID, Rd_ID,
           RegDst_ID, ALUSrc_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, RegWrite_ID, ALUOp_ID,
    input  PC4_EX, ReadData1_EX, ReadData2_EX, SignExt_EX, Rs_EX, Rt_EX, Rd_EX,
           RegDst_EX, ALUSrc_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, RegWrite_EX, ALUOp_EX,
           PCWrite, IFID_Write, Stall, BubbleCount
  );

  modport slave (
    input  Flush, PC4_ID, ReadData1_ID, ReadData2_ID, SignExt_ID, Rs_ID, Rt_ID, Rd_ID,
           RegDst_ID, ALUSrc_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, RegWrite_ID, ALUOp_ID,
    output PC4_EX, ReadData1_EX, ReadData2_EX, SignExt_EX, Rs_EX, Rt_EX, Rd_EX,
           RegDst_EX, ALUSrc_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, RegWrite_EX, ALUOp_EX,
           PCWrite, IFID_Write, Stall, BubbleCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbling and a saturating bubble counter.
module id_ex_stage (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic [31:0] pc4, rd1, rd2, sext;
    logic [4:0]  rs, rt, rd;
    logic        reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write;
    logic [2:0]  alu_op;
  } ex_t;

  ex_t         ex_d, ex_q;
  logic [15:0] cnt_q;
  logic        hazard, bubble;

  assign ex_d = {bus.PC4_ID, bus.ReadData1_ID, bus.ReadData2_ID, bus.SignExt_ID,
                 bus.Rs_ID, bus.Rt_ID, bus.Rd_ID,
                 bus.RegDst_ID, bus.ALUSrc_ID, bus.MemRead_ID, bus.MemWrite_ID,
                 bus.MemtoReg_ID, bus.RegWrite_ID, bus.ALUOp_ID};

  // ex_q is cleared asynchronously, so hazard is inherently 0 while reset is held.
  assign hazard = ex_q.mem_read && (ex_q.rt != 5'd0) &&
                  ((ex_q.rt == bus.Rs_ID) || (ex_q.rt == bus.Rt_ID)) && !bus.Flush;
  assign bubble = hazard || bus.Flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q <= bubble ? '0 : ex_d;
      if (bubble && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.Stall       = hazard;
  assign bus.PCWrite     = !hazard;
  assign bus.IFID_Write  = !hazard;
  assign bus.BubbleCount = cnt_q;

  assign bus.PC4_EX       = ex_q.pc4;
  assign bus.ReadData1_EX = ex_q.rd1;
  assign bus.ReadData2_EX = ex_q.rd2;
  assign bus.SignExt_EX   = ex_q.sext;
  assign bus.Rs_EX        = ex_q.rs;
  assign bus.Rt_EX        = ex_q.rt;
  assign bus.Rd_EX        = ex_q.rd;
  assign bus.RegDst_EX    = ex_q.reg_dst;
  assign bus.ALUSrc_EX    = ex_q.alu_src;
  assign bus.MemRead_EX   = ex_q.mem_read;
  assign bus.MemWrite_EX  = ex_q.mem_write;
  assign bus.MemtoReg_EX  = ex_q.mem_to_reg;
  assign bus.RegWrite_EX  = ex_q.reg_write;
  assign bus.ALUOp_EX     = ex_q.alu_op;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX state and bubble count queued at drive time, popped after the edge.
module tb_id_ex_stage;
  typedef struct packed {
    logic [31:0] pc4, rd1, rd2, sext;
    logic [4:0]  rs, rt, rd;
    logic        reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write;
    logic [2:0]  alu_op;
  } ex_t;

  typedef struct packed {
    ex_t         ex;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  ex_t  m_ex;
  logic [15:0] m_cnt;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [151:0] obs, input logic [151:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic ex_t ex_obs();
    return {bus.PC4_EX, bus.ReadData1_EX, bus.ReadData2_EX, bus.SignExt_EX,
            bus.Rs_EX, bus.Rt_EX, bus.Rd_EX,
            bus.RegDst_EX, bus.ALUSrc_EX, bus.MemRead_EX, bus.MemWrite_EX,
            bus.MemtoReg_EX, bus.RegWrite_EX, bus.ALUOp_EX};
  endfunction

  task automatic drive(input ex_t id, input logic fl);
    bus.Flush        = fl;
    bus.PC4_ID       = id.pc4;
    bus.ReadData1_ID = id.rd1;
    bus.ReadData2_ID = id.rd2;
    bus.SignExt_ID   = id.sext;
    bus.Rs_ID        = id.rs;
    bus.Rt_ID        = id.rt;
    bus.Rd_ID        = id.rd;
    bus.RegDst_ID    = id.reg_dst;
    bus.ALUSrc_ID    = id.alu_src;
    bus.MemRead_ID   = id.mem_read;
    bus.MemWrite_ID  = id.mem_write;
    bus.MemtoReg_ID  = id.mem_to_reg;
    bus.RegWrite_ID  = id.reg_write;
    bus.ALUOp_ID     = id.alu_op;
  endtask

  // Reference hazard from the bench's own view of what sits in EX.
  function automatic logic mhaz(input ex_t id, input logic fl);
    return m_ex.mem_read && m_ex.rt != 5'd0 && (m_ex.rt == id.rs || m_ex.rt == id.rt) && !fl;
  endfunction

  function automatic ex_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic mr);
    ex_t e;
    e = {$urandom, $urandom, $urandom, $urandom, 5'd0, 5'd0, 5'($urandom), 6'($urandom), 3'($urandom)};
    e.rs = rs;
    e.rt = rt;
    e.mem_read = mr;
    return e;
  endfunction

  task automatic step(input ex_t id, input logic fl, input logic st);
    exp_t e;
    @(negedge clk);
    drive(id, fl);
    #1;
    chk("stall", 152'(bus.Stall), 152'(st));
    chk("pcwrite", 152'(bus.PCWrite), 152'(!st));
    chk("ifid_write", 152'(bus.IFID_Write), 152'(!st));
    e.ex = (st || fl) ? '0 : id;
    if ((st || fl) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    e.cnt = m_cnt;
    m_ex = e.ex;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ex_regs", ex_obs(), e.ex);
    chk("bubble_cnt", 152'(bus.BubbleCount), 152'(e.cnt));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ex"}, ex_obs(), '0);
    chk({tag, "_cnt"}, 152'(bus.BubbleCount), '0);
    chk({tag, "_stall"}, 152'(bus.Stall), '0);
    chk({tag, "_pcw"}, 152'(bus.PCWrite), 152'(1));
    chk({tag, "_ifid"}, 152'(bus.IFID_Write), 152'(1));
  endtask

  initial begin
    ex_t id;
    m_ex = '0;
    m_cnt = '0;

    // Reset held across two edges with busy ID inputs.
    id = mk(5'd9, 5'd9, 1'b1);
    id.reg_write = 1'b1;
    drive(id, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst");
    @(negedge clk);
    reset = 1'b1;

    // Pass-through.
    id = '0;
    id.rd1 = 32'h1234_5678;
    id.rs = 5'd8;
    id.reg_write = 1'b1;
    step(id, 1'b0, 1'b0);
    chk("pass_rd1", 152'(bus.ReadData1_EX), 152'(32'h1234_5678));
    chk("pass_rs", 152'(bus.Rs_EX), 152'(5'd8));

    // Load-use on Rs: lw $9, then consumer of $9 stalls once, then advances.
    step(mk(5'd1, 5'd9, 1'b1), 1'b0, 1'b0);
    id = mk(5'd9, 5'd2, 1'b0);
    step(id, 1'b0, 1'b1);
    chk("lu_cnt", 152'(bus.BubbleCount), 152'(16'd1));
    step(id, 1'b0, 1'b0);
    chk("lu_rs", 152'(bus.Rs_EX), 152'(5'd9));

    // $0 never hazards; Rt match does.
    step(mk(5'd3, 5'd0, 1'b1), 1'b0, 1'b0);
    step(mk(5'd0, 5'd0, 1'b0), 1'b0, 1'b0);
    step(mk(5'd3, 5'd5, 1'b1), 1'b0, 1'b0);
    id = mk(5'd3, 5'd5, 1'b0);
    step(id, 1'b0, 1'b1);
    step(id, 1'b0, 1'b0);

    // Flush wins over hazard: no stall, single bubble.
    step(mk(5'd4, 5'd7, 1'b1), 1'b0, 1'b0);
    step(mk(5'd7, 5'd1, 1'b0), 1'b1, 1'b0);
    chk("flush_cnt", 152'(bus.BubbleCount), 152'(16'd3));

    // Random stream over a small register set to hit matches often.
    for (int i = 0; i < 40; i++) begin
      logic fl;
      id = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom));
      fl = ($urandom_range(0, 7) == 0);
      step(id, fl, mhaz(id, fl));
    end

    // Reset asserted mid-stall clears the hazard at once.
    step(mk(5'd1, 5'd4, 1'b1), 1'b0, mhaz(mk(5'd1, 5'd4, 1'b1), 1'b0));
    @(negedge clk);
    id = mk(5'd4, 5'd2, 1'b0);
    drive(id, 1'b0);
    #1;
    chk("pre_rst_stall", 152'(bus.Stall), 152'(m_ex.mem_read && m_ex.rt == 5'd4));
    reset = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    m_ex = '0;
    m_cnt = '0;
    @(posedge clk);
    #1;
    chk_reset_state("mid_rst_edge");
    @(negedge clk);
    reset = 1'b1;
    step(id, 1'b0, 1'b0);
    chk("post_rst_rs", 152'(bus.Rs_EX), 152'(5'd4));

    // Saturation: count up to FFFE via flushes, then three more flushes.
    for (int i = 0; i < 65534; i++) step(mk(5'd1, 5'd1, 1'b0), 1'b1, 1'b0);
    chk("sat_pre", 152'(bus.BubbleCount), 152'(16'hFFFE));
    for (int i = 0; i < 3; i++) begin
      step(mk(5'd1, 5'd1, 1'b0), 1'b1, 1'b0);
      chk("sat_hold", 152'(bus.BubbleCount), 152'(16'hFFFF));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between instruction decode (ID) and execute (EX) for the five-stage MIPS core, with integrated load-use hazard detection. It captures decoded operands, register addresses and control bits each cycle and presents them to EX. The registered Rs/Rt addresses are the ones the forwarding unit compares against the MEM/WB destinations. On a load-use hazard it stalls PC and IF/ID and inserts a bubble. On a flush it inserts a bubble. It also keeps a saturating bubble counter for performance monitoring.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register addresses).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- Flush  in  1  discard the ID instruction (taken branch/jump); bubble into EX
- PC4_ID  in  32  PC+4 of the ID instruction
- ReadData1_ID, ReadData2_ID  in  32 each  register file outputs
- SignExt_ID  in  32  sign-extended immediate
- Rs_ID, Rt_ID, Rd_ID  in  5 each  instruction register fields
- RegDst_ID, ALUSrc_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, RegWrite_ID  in  1 each  control bits
- ALUOp_ID  in  3  ALU operation class
- PC4_EX, ReadData1_EX, ReadData2_EX, SignExt_EX  out  32 each  registered copies
- Rs_EX, Rt_EX, Rd_EX  out  5 each  registered addresses (Rs_EX/Rt_EX drive forwarding)
- RegDst_EX, ALUSrc_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, RegWrite_EX  out  1 each  registered control
- ALUOp_EX  out  3  registered ALU op
- PCWrite  out  1  combinational; 0 = hold PC
- IFID_Write  out  1  combinational; 0 = hold IF/ID register
- Stall  out  1  combinational; 1 when a load-use hazard is detected this cycle
- BubbleCount  out  16  registered count of bubbles inserted; saturates

## Operation
- Hazard = MemRead_EX & (Rt_EX != 0) & ((Rt_EX == Rs_ID) | (Rt_EX == Rt_ID)) & ~Flush.
- Stall = Hazard. PCWrite = IFID_Write = ~Hazard.
- Bubble = Hazard | Flush.
- Each rising clk edge:
  - If Bubble = 0, every *_EX register loads its *_ID input.
  - If Bubble = 1, every *_EX register, data and address fields included, loads 0. A bubble therefore has Rs_EX = Rt_EX = Rd_EX = 0 and RegWrite_EX = MemRead_EX = MemWrite_EX = 0.
- Flush has priority over Hazard. The ID instruction is discarded, so no stall is raised (PCWrite = IFID_Write = 1) and a single bubble is inserted.
- A hazard lasts exactly one cycle. The bubble clears MemRead_EX, so the held ID instruction advances on the next edge and the forwarding unit then supplies the load data from MEM/WB.
- BubbleCount increments by 1 on each edge where Bubble = 1. It stays at 16'hFFFF once reached, with no wrap.
- Register $0 never creates a hazard, even when a load targets $0.

## Timing
- All *_EX outputs and BubbleCount have 1-cycle latency from their ID inputs; they change only on the rising clk edge.
- PCWrite, IFID_Write and Stall are purely combinational from the *_ID inputs, Flush, MemRead_EX and Rt_EX. They are valid within the same cycle, before the edge.
- reset low forces all *_EX outputs and BubbleCount to 0 immediately, without waiting for clk. While reset is low:
  - Stall = 0
  - PCWrite = 1
  - IFID_Write = 1
- reset deassertion mid-stream: the first edge after release captures ID inputs normally. No spurious bubble is inserted and no count is taken.
- Reset asserted during a stall cycle: the hazard clears at once (MemRead_EX = 0) and the count restarts from 0.

## Test plan
- Reset: drive non-zero ID inputs, hold reset low across two edges. Required: all *_EX = 0, BubbleCount = 0, PCWrite = IFID_Write = 1, Stall = 0.
- Pass-through: reset high, ReadData1_ID = 32'h1234_5678, Rs_ID = 5'd8, RegWrite_ID = 1, no hazard or flush. Required: one edge later ReadData1_EX = 32'h1234_5678, Rs_EX = 8, RegWrite_EX = 1; BubbleCount unchanged.
- Load-use stall: an lw with Rt = 9 is in EX (MemRead_EX = 1, Rt_EX = 9); ID holds Rs_ID = 9. Required:
  - Same cycle: Stall = 1, PCWrite = 0, IFID_Write = 0.
  - Next edge: all *_EX = 0, BubbleCount += 1.
  - Following edge: the held ID instruction enters EX with Rs_EX = 9 and Stall = 0.
- $0 and Rt match: MemRead_EX = 1, Rt_EX = 0, Rs_ID = 0 gives Stall = 0. MemRead_EX = 1, Rt_EX = 5, Rt_ID = 5 gives Stall = 1.
- Flush vs hazard: hazard condition true and Flush = 1 in the same cycle. Required: Stall = 0, PCWrite = 1, IFID_Write = 1; next edge bubble; BubbleCount increments by exactly 1.
- Saturation: force BubbleCount to 16'hFFFE and apply Flush for three consecutive cycles. Required: 16'hFFFF after the first edge, and it stays at 16'hFFFF.
